// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED PIO write arbiter.
package led_arb_pkg;

    // Arbiter transaction phases; READ only exists with readback verification.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    // PIO s1 register offset of the output data register.
    localparam logic [1:0] PIO_LED_ADDR = 2'd0;

    // Avalon-MM data bus width of the PIO slave.
    localparam int PIO_BUS_W = 32;

    // Largest requester count supported by the 3-bit grant index.
    localparam int MAX_REQ = 8;

endpackage

// File: rtl/led_pio_write_arbiter_if.sv
// Requester handshake, status and PIO s1 bus signals of the LED arbiter.
// The slave modport is the arbiter's view, master is the environment's view.
interface led_pio_write_arbiter_if
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic [2:0]                grant_idx;
    logic [DATA_W-1:0]         led_shadow;
    logic [1:0]                pio_address;
    logic                      pio_chipselect;
    logic                      pio_write_n;
    logic [PIO_BUS_W-1:0]      pio_writedata;
    logic [PIO_BUS_W-1:0]      pio_readdata;
    logic                      verify_clr;
    logic                      verify_err;

    modport slave (
        input  req, req_data, pio_readdata, verify_clr,
        output ack, busy, grant_idx, led_shadow,
               pio_address, pio_chipselect, pio_write_n, pio_writedata,
               verify_err
    );

    modport master (
        output req, req_data, pio_readdata, verify_clr,
        input  ack, busy, grant_idx, led_shadow,
               pio_address, pio_chipselect, pio_write_n, pio_writedata,
               verify_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin requester pick: combinational one-hot grant searching upward
// from the rotating pointer, pointer advanced past the winner on enable.
module rr_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [2:0]         idx_o,
    output logic               valid_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [2:0]       ptr_q;
    logic [2:0]       ptr_d;
    logic [IDX_W-1:0] candIdx;
    logic             found;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found   = 1'b0;
        candIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candIdx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_i[candIdx]) begin
                found          = 1'b1;
                idx_o          = 3'(candIdx);
                gnt_o[candIdx] = 1'b1;
            end
        end
    end

    assign valid_o = found;
    assign ptr_d   = (idx_o == 3'(NUM_REQ - 1)) ? 3'd0 : idx_o + 3'd1;

    // Rotate the pointer just past the winner whenever a grant is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 3'd0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/led_pio_write_arbiter.sv
// Shares the LED PIO s1 output register among NUM_REQ requesters: round-robin
// grant, latch winner's value, one Avalon write, one-cycle ack to the winner.
// Optional feature macro: LED_ARB_READBACK_EN adds a read-back cycle after the
// write and a sticky verify_err flag on mismatch.
module led_pio_write_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    led_pio_write_arbiter_if.slave  arb_if
);

    arb_state_t           state_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   gntMask_q;
    logic [2:0]           grantIdx_q;
    logic [DATA_W-1:0]    data_q;
    logic [DATA_W-1:0]    ledShadow_q;
    logic                 pioCs_q;
    logic                 pioWrN_q;
    logic [1:0]           pioAddr_q;
    logic [PIO_BUS_W-1:0] pioWdata_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   arbGnt;
    logic [2:0]           arbIdx;
    logic                 arbValid;
    logic                 arbEn;
    logic [DATA_W-1:0]    winData;

    assign arbEn = (state_q == IDLE) && arbValid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (arb_if.req),
        .en_i    (arbEn),
        .gnt_o   (arbGnt),
        .idx_o   (arbIdx),
        .valid_o (arbValid)
    );

    // Select the winner's data slice through the one-hot grant.
    always_comb begin
        winData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arbGnt[i]) begin
                winData = arb_if.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM with registered Avalon drive, ack pulse and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ack_q       <= '0;
            gntMask_q   <= '0;
            grantIdx_q  <= 3'd0;
            data_q      <= '0;
            ledShadow_q <= '0;
            pioCs_q     <= 1'b0;
            pioWrN_q    <= 1'b1;
            pioAddr_q   <= 2'd0;
            pioWdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arbValid) begin
                        state_q    <= WRITE;
                        busy_q     <= 1'b1;
                        grantIdx_q <= arbIdx;
                        gntMask_q  <= arbGnt;
                        data_q     <= winData;
                        pioCs_q    <= 1'b1;
                        pioWrN_q   <= 1'b0;
                        pioAddr_q  <= PIO_LED_ADDR;
                        pioWdata_q <= {{(PIO_BUS_W-DATA_W){1'b0}}, winData};
                    end
                end
                WRITE: begin
                    ledShadow_q <= data_q;
                    pioWrN_q    <= 1'b1;
`ifdef LED_ARB_READBACK_EN
                    state_q     <= READ;
                    pioCs_q     <= 1'b1;
`else
                    state_q     <= ACK;
                    pioCs_q     <= 1'b0;
                    ack_q       <= gntMask_q;
`endif
                end
                READ: begin
                    state_q <= ACK;
                    pioCs_q <= 1'b0;
                    ack_q   <= gntMask_q;
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef LED_ARB_READBACK_EN
    logic verifyErr_q;
    logic unused_ok;

    // Sticky readback mismatch flag; a new mismatch beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            verifyErr_q <= 1'b0;
        end else if ((state_q == READ) &&
                     (arb_if.pio_readdata[DATA_W-1:0] != data_q)) begin
            verifyErr_q <= 1'b1;
        end else if (arb_if.verify_clr) begin
            verifyErr_q <= 1'b0;
        end
    end

    assign arb_if.verify_err = verifyErr_q;
    assign unused_ok = &{1'b0, arb_if.pio_readdata[PIO_BUS_W-1:DATA_W]};
`else
    logic unused_ok;

    assign arb_if.verify_err = 1'b0;
    assign unused_ok = &{1'b0, arb_if.verify_clr, arb_if.pio_readdata};
`endif

    assign arb_if.ack            = ack_q;
    assign arb_if.busy           = busy_q;
    assign arb_if.grant_idx      = grantIdx_q;
    assign arb_if.led_shadow     = ledShadow_q;
    assign arb_if.pio_address    = pioAddr_q;
    assign arb_if.pio_chipselect = pioCs_q;
    assign arb_if.pio_write_n    = pioWrN_q;
    assign arb_if.pio_writedata  = pioWdata_q;

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Directed bench for the LED PIO write arbiter with a small PIO register model.
// Works in both builds; readback checks appear when LED_ARB_READBACK_EN is set.
module tb_led_pio_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
`ifdef LED_ARB_READBACK_EN
    localparam int RAND_GRANTS = 100;
`else
    localparam int RAND_GRANTS = 20;
`endif

    logic       clk;
    logic       reset_n;
    logic       faultyModel;
    logic [7:0] pioReg;
    logic [7:0] dv [4];
    int         assertCount;
    int         failCount;
    int         ptrModel;

    led_pio_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus_if ();

    led_pio_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .arb_if  (bus_if)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO output register model; faultyModel forces reads to return zero.
    always @(posedge clk) begin
        if (bus_if.pio_chipselect && !bus_if.pio_write_n && bus_if.pio_address == 2'd0)
            pioReg <= bus_if.pio_writedata[7:0];
    end
    assign bus_if.pio_readdata = faultyModel ? 32'h0 : {24'h0, pioReg};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqVal, input logic [7:0] d0,
                                 input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        bus_if.req      = reqVal;
        bus_if.req_data = {d3, d2, d1, d0};
    endtask

    task automatic expectWrite(input int idx, input logic [7:0] val, input string tag);
        tick();
        checkOutput({tag, "_busy"},  32'(bus_if.busy), 32'd1);
        checkOutput({tag, "_cs"},    32'(bus_if.pio_chipselect), 32'd1);
        checkOutput({tag, "_wn"},    32'(bus_if.pio_write_n), 32'd0);
        checkOutput({tag, "_addr"},  32'(bus_if.pio_address), 32'd0);
        checkOutput({tag, "_wdata"}, bus_if.pio_writedata, {24'h0, val});
        checkOutput({tag, "_gidx"},  32'(bus_if.grant_idx), 32'(idx));
        checkOutput({tag, "_ack"},   32'(bus_if.ack), 32'd0);
    endtask

    task automatic expectRead(input logic [7:0] val, input string tag);
        tick();
        checkOutput({tag, "_rd_cs"},     32'(bus_if.pio_chipselect), 32'd1);
        checkOutput({tag, "_rd_wn"},     32'(bus_if.pio_write_n), 32'd1);
        checkOutput({tag, "_rd_addr"},   32'(bus_if.pio_address), 32'd0);
        checkOutput({tag, "_rd_ack"},    32'(bus_if.ack), 32'd0);
        checkOutput({tag, "_rd_shadow"}, 32'(bus_if.led_shadow), 32'(val));
    endtask

    task automatic expectAck(input int idx, input logic [7:0] val, input string tag);
        logic [3:0] m;
        m = 4'd0;
        m[idx] = 1'b1;
        tick();
        checkOutput({tag, "_ack"},    32'(bus_if.ack), 32'(m));
        checkOutput({tag, "_shadow"}, 32'(bus_if.led_shadow), 32'(val));
        checkOutput({tag, "_ackcs"},  32'(bus_if.pio_chipselect), 32'd0);
        checkOutput({tag, "_ackwn"},  32'(bus_if.pio_write_n), 32'd1);
        checkOutput({tag, "_ackbusy"}, 32'(bus_if.busy), 32'd1);
    endtask

    task automatic expectIdle(input string tag);
        tick();
        checkOutput({tag, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
        checkOutput({tag, "_idle_ack"},  32'(bus_if.ack), 32'd0);
        checkOutput({tag, "_idle_cs"},   32'(bus_if.pio_chipselect), 32'd0);
    endtask

    // Full transaction from the IDLE cycle in which the request is sampled.
    task automatic expectTxn(input int idx, input logic [7:0] val, input string tag);
        expectWrite(idx, val, tag);
`ifdef LED_ARB_READBACK_EN
        expectRead(val, tag);
`endif
        expectAck(idx, val, tag);
    endtask

    function automatic int pickModel(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        int w;
        logic [3:0] r;
        assertCount = 0;
        failCount   = 0;
        faultyModel = 1'b0;
        reset_n     = 1'b0;
        bus_if.verify_clr = 1'b0;
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset values
        tick();
        tick();
        checkOutput("rst_ack",    32'(bus_if.ack), 32'd0);
        checkOutput("rst_busy",   32'(bus_if.busy), 32'd0);
        checkOutput("rst_gidx",   32'(bus_if.grant_idx), 32'd0);
        checkOutput("rst_shadow", 32'(bus_if.led_shadow), 32'd0);
        checkOutput("rst_cs",     32'(bus_if.pio_chipselect), 32'd0);
        checkOutput("rst_wn",     32'(bus_if.pio_write_n), 32'd1);
        checkOutput("rst_addr",   32'(bus_if.pio_address), 32'd0);
        checkOutput("rst_wdata",  bus_if.pio_writedata, 32'd0);
        checkOutput("rst_verr",   32'(bus_if.verify_err), 32'd0);
        reset_n = 1'b1;
        expectIdle("t1_pre");

        // Test 1: single requester 1 with A5
        applyStimulus(4'b0010, 8'h00, 8'hA5, 8'h00, 8'h00);
        expectTxn(1, 8'hA5, "t1");
        applyStimulus(4'b0000, 8'h00, 8'hA5, 8'h00, 8'h00);
        expectIdle("t1_post");

        // Test 2: all requesting from a fresh reset, rotation 0,1,2,3,0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        applyStimulus(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        expectTxn(0, 8'h10, "t2_g0");
        expectIdle("t2_i0");
        expectTxn(1, 8'h11, "t2_g1");
        expectIdle("t2_i1");
        expectTxn(2, 8'h12, "t2_g2");
        expectIdle("t2_i2");
        expectTxn(3, 8'h13, "t2_g3");
        expectIdle("t2_i3");
        expectTxn(0, 8'h10, "t2_g4");
        applyStimulus(4'b0000, 8'h10, 8'h11, 8'h12, 8'h13);
        expectIdle("t2_post");

        // Test 3: req0 drops and data changes during WRITE; req2 then wins
        applyStimulus(4'b0001, 8'h3C, 8'h11, 8'h12, 8'h13);
        expectWrite(0, 8'h3C, "t3_w0");
        applyStimulus(4'b0100, 8'hFF, 8'h11, 8'h12, 8'h13);
`ifdef LED_ARB_READBACK_EN
        expectRead(8'h3C, "t3_r0");
        checkOutput("t3_rd_wdata", bus_if.pio_writedata, 32'h3C);
`endif
        expectAck(0, 8'h3C, "t3_a0");
        expectIdle("t3_i");
        expectTxn(2, 8'h12, "t3_g2");
        applyStimulus(4'b0000, 8'hFF, 8'h11, 8'h12, 8'h13);
        expectIdle("t3_post");

        // Test 4: reset during WRITE aborts; next grant restarts at req0
        applyStimulus(4'b0010, 8'h21, 8'h77, 8'h22, 8'h23);
        expectWrite(1, 8'h77, "t4_w");
        reset_n = 1'b0;
        #1;
        checkOutput("t4_abort_cs",     32'(bus_if.pio_chipselect), 32'd0);
        checkOutput("t4_abort_wn",     32'(bus_if.pio_write_n), 32'd1);
        checkOutput("t4_abort_busy",   32'(bus_if.busy), 32'd0);
        checkOutput("t4_abort_ack",    32'(bus_if.ack), 32'd0);
        checkOutput("t4_abort_shadow", 32'(bus_if.led_shadow), 32'd0);
        tick();
        checkOutput("t4_hold_ack", 32'(bus_if.ack), 32'd0);
        reset_n = 1'b1;
        applyStimulus(4'b1111, 8'h21, 8'h77, 8'h22, 8'h23);
        expectTxn(0, 8'h21, "t4_g0");
        applyStimulus(4'b0000, 8'h21, 8'h77, 8'h22, 8'h23);
        expectIdle("t4_post");
        ptrModel = 1;

`ifdef LED_ARB_READBACK_EN
        // Test 5: faulty PIO model returns zero, verify_err sticks until cleared
        faultyModel = 1'b1;
        applyStimulus(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00);
        expectWrite(0, 8'h5A, "t5_w");
        expectRead(8'h5A, "t5_r");
        checkOutput("t5_rd_verr", 32'(bus_if.verify_err), 32'd0);
        expectAck(0, 8'h5A, "t5_a");
        checkOutput("t5_ack_verr", 32'(bus_if.verify_err), 32'd1);
        applyStimulus(4'b0000, 8'h5A, 8'h00, 8'h00, 8'h00);
        expectIdle("t5_i");
        checkOutput("t5_sticky", 32'(bus_if.verify_err), 32'd1);
        bus_if.verify_clr = 1'b1;
        tick();
        checkOutput("t5_clr", 32'(bus_if.verify_err), 32'd0);

        // Test 5b: mismatch beats a simultaneous clear
        applyStimulus(4'b0010, 8'h00, 8'h6B, 8'h00, 8'h00);
        expectTxn(1, 8'h6B, "t5b");
        checkOutput("t5b_set_wins", 32'(bus_if.verify_err), 32'd1);
        applyStimulus(4'b0000, 8'h00, 8'h6B, 8'h00, 8'h00);
        tick();
        checkOutput("t5b_clr", 32'(bus_if.verify_err), 32'd0);
        bus_if.verify_clr = 1'b0;
        faultyModel = 1'b0;
        ptrModel = 2;
`endif

        // Test 6: random requests and data against a round-robin model
        for (int n = 0; n < RAND_GRANTS; n++) begin
            r = 4'($urandom_range(1, 15));
            applyStimulus(r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            w = pickModel(r, ptrModel);
            expectTxn(w, dv[w], "t6");
            ptrModel = (w + 1) % 4;
            applyStimulus(4'b0000, dv[0], dv[1], dv[2], dv[3]);
            expectIdle("t6");
        end
        checkOutput("t6_verr", 32'(bus_if.verify_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
